// File: rtl/descriptor_mem_pkg.sv
// Shared definitions for the descriptor RAM arbiter: default widths,
// requester identifiers and counter sizes.
package descriptor_mem_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 32;
  localparam int GNT_CNT_W      = 16;
  // Wide enough for any lock length up to 255 transfers.
  localparam int LOCK_CNT_W     = 8;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_e;

endpackage : descriptor_mem_pkg

// File: rtl/descriptor_rr_grant.sv
// Two-way round-robin grant with a bounded lock. A lock keeps the grant with
// its owner for up to MAX_LOCK accepted transfers; when the budget runs out
// last_grant points at the owner, so round-robin hands the next contended
// slot to the other port.
module descriptor_rr_grant
  import descriptor_mem_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic       gnt_valid,
  output req_id_e    gnt_idx
);

  req_id_e                 last_grant_q, last_grant_d;
  req_id_e                 lock_owner_q, lock_owner_d;
  logic                    lock_active_q, lock_active_d;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [LOCK_CNT_W-1:0]   lock_base;

  // Grant decision: live lock owner first, then single requester, then round-robin.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt_valid = |req;
    gnt_idx   = REQ_HOST;
    if (lock_active_q && req[lock_owner_q]) begin
      gnt_idx = lock_owner_q;
    end else if (req[0] && req[1]) begin
      gnt_idx = (last_grant_q == REQ_HOST) ? REQ_DMA : REQ_HOST;
    end else if (req[1]) begin
      gnt_idx = REQ_DMA;
    end
  end

  // Next state of round-robin pointer and lock tracking. A grant here is always
  // an accepted transfer because the top qualifies waitrequest with the request.
  always_comb begin
    last_grant_d  = last_grant_q;
    lock_owner_d  = lock_owner_q;
    lock_active_d = lock_active_q;
    lock_cnt_d    = lock_cnt_q;
    // A fresh lock (new owner or no live lock) counts from zero.
    lock_base     = (lock_active_q && (lock_owner_q == gnt_idx)) ? lock_cnt_q : '0;
    if (gnt_valid) begin
      last_grant_d = gnt_idx;
      if (lock[gnt_idx]) begin
        if (lock_base == LOCK_CNT_W'(MAX_LOCK - 1)) begin
          lock_active_d = 1'b0;
          lock_cnt_d    = '0;
        end else begin
          lock_active_d = 1'b1;
          lock_owner_d  = gnt_idx;
          lock_cnt_d    = lock_base + 1'b1;
        end
      end else begin
        lock_active_d = 1'b0;
        lock_cnt_d    = '0;
      end
    end else if (lock_active_q && !req[lock_owner_q]) begin
      lock_active_d = 1'b0;
      lock_cnt_d    = '0;
    end
  end

  // State registers; last_grant resets to DMA so the host wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= REQ_DMA;
      lock_owner_q  <= REQ_HOST;
      lock_active_q <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      last_grant_q  <= last_grant_d;
      lock_owner_q  <= lock_owner_d;
      lock_active_q <= lock_active_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

endmodule : descriptor_rr_grant

// File: rtl/descriptor_mem_arbiter.sv
// Shares the single-port descriptor RAM between the host CPU (port 0) and the
// TCP DMA descriptor-fetch engine (port 1). One access per cycle; read data
// returns one cycle after issue, tagged to the requester that issued it.
module descriptor_mem_arbiter
  import descriptor_mem_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int MAX_LOCK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    m0_address,
  input  logic [DATA_W/8-1:0]  m0_byteenable,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [DATA_W-1:0]    m0_writedata,
  input  logic                 m0_lock,
  output logic                 m0_waitrequest,
  output logic [DATA_W-1:0]    m0_readdata,
  output logic                 m0_readdatavalid,
  input  logic [ADDR_W-1:0]    m1_address,
  input  logic [DATA_W/8-1:0]  m1_byteenable,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [DATA_W-1:0]    m1_writedata,
  input  logic                 m1_lock,
  output logic                 m1_waitrequest,
  output logic [DATA_W-1:0]    m1_readdata,
  output logic                 m1_readdatavalid,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W/8-1:0]  mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_writedata,
  output logic                 mem_clken,
  input  logic [DATA_W-1:0]    mem_readdata,
  output logic [GNT_CNT_W-1:0] gnt_cnt0,
  output logic [GNT_CNT_W-1:0] gnt_cnt1
);

  logic                 req0, req1, acc0, acc1;
  logic                 gnt_valid;
  req_id_e              gnt_idx;
  logic                 rd_pend_q, rd_pend_d;
  req_id_e              rd_owner_q, rd_owner_d;
  logic [GNT_CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d, gnt_cnt1_q, gnt_cnt1_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  descriptor_rr_grant #(
    .MAX_LOCK (MAX_LOCK)
  ) u_grant (
    .clk       (clk),
    .reset     (reset),
    .req       ({req1, req0}),
    .lock      ({m1_lock, m0_lock}),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Handshake and RAM command mux; the granted port drives the RAM when accepted.
  always_comb begin
    m0_waitrequest = ~(gnt_valid && (gnt_idx == REQ_HOST) && req0) | reset;
    m1_waitrequest = ~(gnt_valid && (gnt_idx == REQ_DMA) && req1) | reset;
    acc0           = req0 & ~m0_waitrequest;
    acc1           = req1 & ~m1_waitrequest;
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (gnt_idx == REQ_DMA) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end
    mem_chipselect = acc0 | acc1;
    // A simultaneous read and write is treated as a write.
    mem_write      = (acc0 & m0_write) | (acc1 & m1_write);
    mem_clken      = 1'b1;
  end

  // Read-return tracking and saturating per-port transfer counters.
  always_comb begin
    rd_pend_d  = (acc0 & ~m0_write) | (acc1 & ~m1_write);
    rd_owner_d = rd_owner_q;
    if (acc0) rd_owner_d = REQ_HOST;
    if (acc1) rd_owner_d = REQ_DMA;
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (acc0 && (gnt_cnt0_q != '1)) gnt_cnt0_d = gnt_cnt0_q + 1'b1;
    if (acc1 && (gnt_cnt1_q != '1)) gnt_cnt1_d = gnt_cnt1_q + 1'b1;
  end

  // Pipeline and counter registers; reset discards any pending read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_HOST;
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  // Both ports see the RAM output; only the owner's valid is raised.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend_q & (rd_owner_q == REQ_HOST) & ~reset;
  assign m1_readdatavalid = rd_pend_q & (rd_owner_q == REQ_DMA) & ~reset;
  assign gnt_cnt0         = gnt_cnt0_q;
  assign gnt_cnt1         = gnt_cnt1_q;

endmodule : descriptor_mem_arbiter

// File: tb/tb_descriptor_mem_arbiter.sv
// Directed bench for descriptor_mem_arbiter with a behavioural 1024x32
// single-port RAM (byte enables, 1-cycle read latency) attached.
module tb_descriptor_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  descriptor_mem_arbiter #(
    .ADDR_W   (10),
    .DATA_W   (32),
    .MAX_LOCK (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_lock          (m0_lock),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_lock          (m1_lock),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .gnt_cnt0         (gnt_cnt0),
    .gnt_cnt1         (gnt_cnt1)
  );

  // RAM model; the known descriptor words are loaded while reset is held.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (reset) begin
      ram[10'h005] <= 32'hDEADBEEF;
      ram[10'h010] <= 32'hA0A00010;
      ram[10'h020] <= 32'hB0B00020;
      ram[10'h3FF] <= 32'hCAFEF00D;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_address = '0; m0_byteenable = 4'hF; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_lock = 0;
    m1_address = '0; m1_byteenable = 4'hF; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_lock = 0;
  endtask

  logic [10:0] lock_seq;
  logic        exp_g;

  initial begin
    // Reset with both ports requesting: nothing may be accepted.
    idle();
    reset = 1'b1;
    m0_read = 1; m1_read = 1;
    tick(); tick();
    check("rst_wait0", m0_waitrequest, 1);
    check("rst_wait1", m1_waitrequest, 1);
    check("rst_cs", mem_chipselect, 0);
    check("rst_we", mem_write, 0);
    check("rst_rdv0", m0_readdatavalid, 0);
    check("rst_rdv1", m1_readdatavalid, 0);
    check("rst_cnt0", gnt_cnt0, 0);
    check("rst_cnt1", gnt_cnt1, 0);

    // Idle, then a single host read of 0x005.
    reset = 1'b0; idle(); #1;
    check("idle_cs", mem_chipselect, 0);
    tick();
    m0_read = 1; m0_address = 10'h005; #1;
    check("rd_wait0", m0_waitrequest, 0);
    check("rd_cs", mem_chipselect, 1);
    check("rd_addr", mem_address, 10'h005);
    check("rd_we", mem_write, 0);
    tick();
    idle(); #1;
    check("rd_rdv0", m0_readdatavalid, 1);
    check("rd_data0", m0_readdata, 32'hDEADBEEF);
    check("rd_rdv1", m1_readdatavalid, 0);
    tick();

    // Host read accepted, then reset in the following cycle.
    m0_read = 1; m0_address = 10'h005; #1;
    check("rr_wait0", m0_waitrequest, 0);
    tick();
    reset = 1'b1; idle(); #1;
    check("rr_rdv0_a", m0_readdatavalid, 0);
    tick();
    check("rr_rdv0_b", m0_readdatavalid, 0);
    check("rr_cnt0", gnt_cnt0, 0);
    check("rr_cnt1", gnt_cnt1, 0);

    // Both ports reading continuously straight out of reset: 0,1,0,1,...
    reset = 1'b0;
    m0_read = 1; m0_address = 10'h010;
    m1_read = 1; m1_address = 10'h020;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_g = i[0];
      check("alt_wait0", m0_waitrequest, exp_g);
      check("alt_wait1", m1_waitrequest, !exp_g);
      if (i > 0) begin
        check("alt_rdv0", m0_readdatavalid, exp_g);
        check("alt_rdv1", m1_readdatavalid, !exp_g);
        check("alt_data", m0_readdata, exp_g ? 32'hA0A00010 : 32'hB0B00020);
      end
      tick();
    end
    idle(); #1;
    check("alt_last_rdv1", m1_readdatavalid, 1);
    check("alt_last_data", m1_readdata, 32'hB0B00020);
    tick();

    // DMA partial write of the low half-word, then host read-back.
    m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'h12345678; m1_byteenable = 4'b0011; #1;
    check("wr_wait1", m1_waitrequest, 0);
    check("wr_we", mem_write, 1);
    check("wr_be", mem_byteenable, 4'b0011);
    check("wr_wdata", mem_writedata, 32'h12345678);
    tick();
    idle();
    m0_read = 1; m0_address = 10'h3FF; #1;
    check("wr_rd_wait0", m0_waitrequest, 0);
    tick();
    idle(); #1;
    check("wr_rdv0", m0_readdatavalid, 1);
    check("wr_merged", m0_readdata, 32'hCAFE5678);
    tick();

    // DMA lock with a budget of 4 while the host keeps requesting.
    reset = 1'b1; tick(); reset = 1'b0;
    lock_seq = 11'b01111011110; // bit i = expected grant index in cycle i
    m0_read = 1; m0_address = 10'h010;
    m1_read = 1; m1_address = 10'h020; m1_lock = 1;
    for (int i = 0; i < 11; i++) begin
      #1;
      exp_g = lock_seq[i];
      check("lock_wait0", m0_waitrequest, exp_g);
      check("lock_wait1", m1_waitrequest, !exp_g);
      tick();
    end
    idle(); #1;
    check("lock_cnt0", gnt_cnt0, 3);
    check("lock_cnt1", gnt_cnt1, 8);
    tick();

    // Counter saturation on port 0.
    reset = 1'b1; tick(); reset = 1'b0;
    m0_read = 1; m0_address = 10'h000;
    repeat (65534) tick();
    check("sat_fffe", gnt_cnt0, 16'hFFFE);
    repeat (3) tick();
    check("sat_ffff", gnt_cnt0, 16'hFFFF);
    check("sat_cnt1", gnt_cnt1, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_descriptor_mem_arbiter
